// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-locked arbiter sharing one UART transmitter
//
// Ports:
//   i_clk32      system clock
//   i_reset      synchronous active-high reset
//   i_req        per-requester byte valid, held until o_req_ack
//   i_req_data   byte of requester i in [8*i+7:8*i]
//   i_req_last   presented byte is the last of its message
//   o_req_ack    one-cycle pulse: byte of requester i taken
//   o_grant      one-hot current owner, zero when idle
//   o_txdata     byte to the UART transmitter
//   o_tx_enable  one-cycle send strobe to the UART transmitter
//   i_tx_ready   UART transmitter ready
//   o_busy       high whenever the arbiter is not idle

module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 3
) (
    input  logic                 i_clk32,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ack,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [7:0]           o_txdata,
    output logic                 o_tx_enable,
    input  logic                 i_tx_ready,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
    logic [7:0]         r_txdata, w_txdata_nxt;
    logic               r_tx_enable, w_tx_enable_nxt;
    logic               r_last, w_last_nxt;
    logic               r_busy, w_busy_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;

    logic [NUM_REQ-1:0] w_pick;
    int                 w_best_d;
    int                 w_dist;
    logic               w_own_req;
    logic               w_own_last;
    logic [7:0]         w_own_data;
    logic [PTR_W-1:0]   w_ptr_rel;

    // Round-robin pick: the requester whose distance ahead of r_ptr
    // (mod NUM_REQ) is smallest wins. Distances are unique, so the
    // result is one-hot or zero.
    always_comb begin
        w_pick   = '0;
        w_best_d = NUM_REQ;
        w_dist   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - int'(r_ptr)) % NUM_REQ;
            if (i_req[i] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pick[i] = i_req[i] && (((i + NUM_REQ - int'(r_ptr)) % NUM_REQ) == w_best_d);
        end
    end

    // Owner-side views selected by the one-hot grant, plus the pointer
    // value the owner hands over on release (owner + 1, wrapping).
    always_comb begin
        w_own_req  = |(i_req & r_grant);
        w_own_last = |(i_req_last & r_grant);
        w_own_data = '0;
        w_ptr_rel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_own_data = i_req_data[8*i +: 8];
                w_ptr_rel  = PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_ack_nxt       = '0;
        w_tx_enable_nxt = 1'b0;
        w_txdata_nxt    = r_txdata;
        w_last_nxt      = r_last;
        w_ptr_nxt       = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (!w_own_req) begin
                    // Owner withdrew: release without sending.
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_rel;
                    w_state_nxt = S_IDLE;
                end else if (i_tx_ready) begin
                    w_txdata_nxt    = w_own_data;
                    w_tx_enable_nxt = 1'b1;
                    w_ack_nxt       = r_grant;
                    w_last_nxt      = w_own_last;
                    w_state_nxt     = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // r_tx_enable is high only in the first cycle here; the
                // UART cannot have reacted yet, so tx_ready is ignored.
                if (!r_tx_enable && !i_tx_ready) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_tx_ready) begin
                    if (r_last) begin
                        w_grant_nxt = '0;
                        w_ptr_nxt   = w_ptr_rel;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_SEND;
                    end
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge i_clk32) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_ack       <= '0;
            r_txdata    <= 8'h00;
            r_tx_enable <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_ack       <= w_ack_nxt;
            r_txdata    <= w_txdata_nxt;
            r_tx_enable <= w_tx_enable_nxt;
            r_last      <= w_last_nxt;
            r_busy      <= w_busy_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign o_req_ack   = r_ack;
    assign o_grant     = r_grant;
    assign o_txdata    = r_txdata;
    assign o_tx_enable = r_tx_enable;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req, last, ack, grant;
    logic [31:0] data;
    logic        rdy, txen, busy;
    logic [7:0]  txdata;

    uart_tx_arbiter #(.NUM_REQ(4), .PTR_W(3)) dut (
        .i_clk32(clk), .i_reset(rst), .i_req(req), .i_req_data(data),
        .i_req_last(last), .o_req_ack(ack), .o_grant(grant), .o_txdata(txdata),
        .o_tx_enable(txen), .i_tx_ready(rdy), .o_busy(busy)
    );

    logic        rst3;
    logic [2:0]  req3, last3, ack3, grant3;
    logic [23:0] data3;
    logic        rdy3, txen3, busy3;
    logic [7:0]  txdata3;

    uart_tx_arbiter #(.NUM_REQ(3), .PTR_W(2)) dut3 (
        .i_clk32(clk), .i_reset(rst3), .i_req(req3), .i_req_data(data3),
        .i_req_last(last3), .o_req_ack(ack3), .o_grant(grant3), .o_txdata(txdata3),
        .o_tx_enable(txen3), .i_tx_ready(rdy3), .o_busy(busy3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_log(input string nm, input logic [7:0] got[$], input logic [7:0] exp[$]);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            chk($sformatf("%s[%0d]", nm, k), (k < got.size()) ? {24'h0, got[k]} : 32'hFFFF_FFFF, {24'h0, exp[k]});
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] oh(input int k);
        return (k < 0) ? 4'h0 : 4'(1 << k);
    endfunction

    // First requesting index found walking p, p+1, ... mod 4.
    function automatic logic [3:0] rr_pick(input logic [3:0] r, input int p);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (r[idx[1:0]]) return oh(idx);
        end
        return 4'h0;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] e_grant;
        logic [3:0] e_ack;
        logic       e_txen;
        logic [7:0] e_txd;
        logic       e_busy;
    } vec_t;

    vec_t vt [23];

    // ---------------- queue-driven harness state ----------------
    logic [8:0] rq [4][$];
    int         gap [4];
    int         gap_max, drop_min, drop_max;
    bit         rand_stall;
    logic [7:0] glog [$];
    logic [7:0] blog [$];

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < 4; i++) n += rq[i].size();
        return n;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            req[i]          = (rq[i].size() > 0) && (gap[i] == 0);
            data[8*i +: 8]  = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            last[i]         = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
        end
    endtask

    task automatic run4(input int budget);
        int         m_ptr   = 0;
        int         m_owner = -1;
        int         rdy_cnt = 0;
        int         cyc     = 0;
        int         ai;
        bit         last_sent = 1'b0;
        logic [3:0] pg = 4'h0;
        logic [3:0] exp_g;
        logic [8:0] hd;
        glog.delete();
        blog.delete();
        rst = 1'b1; req = '0; last = '0; data = '0; rdy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_reqs();
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            chk("onehot", {31'h0, $onehot0(grant)}, 32'h1);
            if (pg == 4'h0) begin
                exp_g = rr_pick(req, m_ptr);
                chk("pick", grant, exp_g);
                if (exp_g != 4'h0) begin
                    glog.push_back({4'h0, grant});
                    m_owner   = idx_of(exp_g);
                    last_sent = 1'b0;
                end
            end else if (grant == 4'h0) begin
                chk("release_after_last", last_sent, 1);
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                chk("lock", grant, pg);
            end
            if (txen) begin
                chk("ready_at_strobe", rdy, 1);
                chk("ack", ack, oh(m_owner));
                ai = idx_of(ack);
                if (ai >= 0 && rq[ai].size() > 0) begin
                    hd = rq[ai].pop_front();
                    chk("txdata", txdata, hd[7:0]);
                    last_sent = hd[8];
                    blog.push_back(txdata);
                    if (hd[8]) gap[ai] = $urandom_range(0, gap_max) + 1;
                end else begin
                    total++;
                    bad++;
                    $display("FAIL strobe_pending got ack=%b exp=ack of requester with pending byte", ack);
                end
            end else begin
                chk("no_stray_ack", ack, 0);
            end
            pg = grant;
            if (pending() == 0 && grant == 4'h0) break;
            if (cyc >= budget) begin
                total++;
                bad++;
                $display("FAIL run_timeout got=%0d cycles exp=<%0d", cyc, budget);
                break;
            end
            if (txen) rdy_cnt = $urandom_range(drop_min, drop_max);
            if (rdy_cnt > 0) begin
                rdy = 1'b0;
                rdy_cnt--;
            end else begin
                rdy = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            for (int i = 0; i < 4; i++) if (gap[i] > 0) gap[i]--;
            drive_reqs();
        end
    endtask

    logic [7:0] eg [$];
    logic [7:0] eb [$];
    logic [7:0] glog3 [$];
    logic [2:0] pg3;
    int         rdy_cnt3;
    int         nbytes;

    initial begin
        rst3 = 1'b1; req3 = '0; last3 = 3'b111; data3 = 24'hC2C1C0; rdy3 = 1'b1;
        data = 32'h66554111;

        //               rst   req   last  rdy   grant ack   txen  txd    busy
        vt[0]  = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1'b0, 4'h2, 4'h2, 1'b1, 4'h2, 4'h0, 1'b0, 8'h00, 1'b1};
        vt[2]  = '{1'b0, 4'h2, 4'h2, 1'b1, 4'h2, 4'h2, 1'b1, 8'h41, 1'b1};
        vt[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h0, 1'b0, 8'h41, 1'b1};
        vt[4]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h0, 1'b0, 8'h41, 1'b1};
        vt[5]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h41, 1'b0};
        vt[6]  = '{1'b0, 4'h8, 4'h8, 1'b0, 4'h8, 4'h0, 1'b0, 8'h41, 1'b1};
        vt[7]  = '{1'b0, 4'h8, 4'h8, 1'b0, 4'h8, 4'h0, 1'b0, 8'h41, 1'b1};
        vt[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h41, 1'b0};
        vt[9]  = '{1'b0, 4'h9, 4'h9, 1'b0, 4'h1, 4'h0, 1'b0, 8'h41, 1'b1};
        vt[10] = '{1'b0, 4'h9, 4'h9, 1'b0, 4'h1, 4'h0, 1'b0, 8'h41, 1'b1};
        vt[11] = '{1'b0, 4'h9, 4'h9, 1'b1, 4'h1, 4'h1, 1'b1, 8'h11, 1'b1};
        vt[12] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 1'b0, 8'h11, 1'b1};
        vt[13] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 1'b0, 8'h11, 1'b1};
        vt[14] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h11, 1'b0};
        vt[15] = '{1'b0, 4'h4, 4'h4, 1'b1, 4'h4, 4'h0, 1'b0, 8'h11, 1'b1};
        vt[16] = '{1'b0, 4'h4, 4'h4, 1'b1, 4'h4, 4'h4, 1'b1, 8'h55, 1'b1};
        vt[17] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h4, 4'h0, 1'b0, 8'h55, 1'b1};
        vt[18] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h4, 4'h0, 1'b0, 8'h55, 1'b1};
        vt[19] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        vt[20] = '{1'b0, 4'h9, 4'h9, 1'b1, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1};
        vt[21] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
        vt[22] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};

        for (int i = 0; i < 23; i++) begin
            rst  = vt[i].rst;
            req  = vt[i].req;
            last = vt[i].last;
            rdy  = vt[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d{grant,ack,txen,txd,busy}", i),
                {14'h0, grant, ack, txen, txdata, busy},
                {14'h0, vt[i].e_grant, vt[i].e_ack, vt[i].e_txen, vt[i].e_txd, vt[i].e_busy});
        end

        // Round robin: everyone pending, requester 0 has a second message.
        gap_max = 0; drop_min = 10; drop_max = 10; rand_stall = 1'b0;
        for (int i = 0; i < 4; i++) gap[i] = 0;
        rq[0].push_back(9'h1A0); rq[0].push_back(9'h1A4);
        rq[1].push_back(9'h1A1); rq[2].push_back(9'h1A2); rq[3].push_back(9'h1A3);
        run4(400);
        eg = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
        eb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        chk_log("rr_grant", glog, eg);
        chk_log("rr_bytes", blog, eb);

        // Message lock: requester 2 waits for the whole 3-byte message.
        drop_min = 2; drop_max = 3;
        for (int i = 0; i < 4; i++) gap[i] = 0;
        rq[0].push_back(9'h010); rq[0].push_back(9'h011); rq[0].push_back(9'h112);
        rq[2].push_back(9'h120);
        run4(200);
        eg = '{8'h01, 8'h04};
        eb = '{8'h10, 8'h11, 8'h12, 8'h20};
        chk_log("lock_grant", glog, eg);
        chk_log("lock_bytes", blog, eb);

        // Randomized traffic against the queue model.
        gap_max = 4; drop_min = 2; drop_max = 5; rand_stall = 1'b1;
        nbytes = 0;
        for (int i = 0; i < 4; i++) begin
            gap[i] = $urandom_range(0, 6);
            for (int m = 0; m < 3; m++) begin
                int n;
                n = $urandom_range(1, 4);
                for (int b = 0; b < n; b++) rq[i].push_back({(b == n - 1), 8'($urandom)});
                nbytes += n;
            end
        end
        run4(4000);
        chk("rand_byte_count", blog.size(), nbytes);

        // NUM_REQ=3 wrap: 2 first, then 0 and 1 pending -> 2, 0, 1.
        @(posedge clk); #1;
        rst3 = 1'b0; req3 = 3'b100; pg3 = 3'b000; rdy_cnt3 = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            chk("onehot3", {31'h0, $onehot0(grant3)}, 32'h1);
            if (pg3 == 3'b000 && grant3 != 3'b000) glog3.push_back({5'h0, grant3});
            if (txen3) begin
                chk("txdata3", txdata3, 8'hC0 + 8'(idx_of({1'b0, ack3})));
                req3     = req3 & ~ack3;
                rdy_cnt3 = 2;
            end
            if (grant3 == 3'b100 && pg3 == 3'b000) req3 = 3'b111;
            pg3 = grant3;
            if (rdy_cnt3 > 0) begin
                rdy3 = 1'b0;
                rdy_cnt3--;
            end else begin
                rdy3 = 1'b1;
            end
            if (glog3.size() == 3 && grant3 == 3'b000) break;
        end
        eg = '{8'h04, 8'h01, 8'h02};
        chk_log("wrap3_grant", glog3, eg);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
